// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_pkg
// Brief    : Shared constants and types for the RV32I instruction fetch stage.
// Revision : 1.0  initial release
// ============================================================================
package if_pkg;

    localparam int IF_ADDR_W = 32;
    localparam int IF_DATA_W = 32;

    // addi x0, x0, 0 -- the canonical bubble
    localparam logic [IF_DATA_W-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [IF_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One fetched instruction together with the address it came from
    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; low address bits are forced to zero
    function automatic logic [IF_ADDR_W-1:0] word_align(input logic [IF_ADDR_W-1:0] addr);
        return {addr[IF_ADDR_W-1:2], 2'b00};
    endfunction

endpackage : if_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO of fetch entries with synchronous clear.
//            Head entry is presented combinationally (show-ahead).
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage array; contents need no reset because the count qualifies them
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : RV32I instruction fetch stage. Owns the fetch PC, issues
//            credit-limited requests to a variable-latency in-order
//            instruction memory, buffers responses and drives the IF/ID
//            pipeline register. Stale fetches after a redirect are dropped.
// Revision : 1.0  initial release
// ============================================================================
module if_stage
    import if_pkg::*;
#(
    parameter int                    DATA_WIDTH  = IF_DATA_W,
    parameter int                    ADDR_WIDTH  = IF_ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int                    FETCH_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [ADDR_WIDTH-1:0] PC_plus_4,
    output logic                  if_valid
);

    localparam int CNT_W = $clog2(FETCH_DEPTH) + 1;
    localparam int PTR_W = $clog2(FETCH_DEPTH);
    localparam int OCC_W = CNT_W + 1;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic                  r_rst_q;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_pq [FETCH_DEPTH];
    logic [PTR_W-1:0]      r_pq_rd;
    logic [PTR_W-1:0]      r_pq_wr;
    logic [CNT_W-1:0]      r_pq_cnt;
    logic [CNT_W-1:0]      r_discard_cnt;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pc4;
    logic                  r_if_valid;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [OCC_W-1:0] w_occ;
    logic             w_req_fire;
    logic             w_discarding;
    logic             w_pq_pop;
    logic             w_rsp_take;
    logic             w_load_ok;
    logic             w_bypass;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W-1:0] w_redirect_discard;
    fetch_entry_t     w_rsp_entry;
    fetch_entry_t     w_fifo_head;

    // Credit counts every fetch not yet handed to IF/ID, including ones that
    // will be thrown away, so the FIFO can never overflow.
    assign w_occ = OCC_W'(r_pq_cnt) + OCC_W'(r_discard_cnt) + OCC_W'(w_fifo_count);

    // Request is a function of registered state only
    assign imem_req_valid = !r_rst_q && (w_occ < OCC_W'(FETCH_DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_discarding = (r_discard_cnt != '0);
    assign w_pq_pop     = imem_rsp_valid && !w_discarding;
    assign w_rsp_take   = w_pq_pop && !redirect_valid;

    // IF/ID may take a real instruction this cycle
    assign w_load_ok    = !stall && !flush && !redirect_valid;
    assign w_bypass     = w_rsp_take && w_fifo_empty && w_load_ok;
    assign w_fifo_push  = w_rsp_take && !w_bypass && !w_fifo_full;
    assign w_fifo_pop   = w_load_ok && !w_fifo_empty;

    assign w_rsp_entry  = '{pc: r_pq[r_pq_rd], instr: imem_rsp_data};

    // Responses still owed by memory once a redirect lands: everything
    // outstanding, plus this cycle's accepted request, minus this cycle's response
    assign w_redirect_discard = r_pq_cnt + r_discard_cnt
                              + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);

    // ------------------------------------------------------------------------
    // Buffered responses waiting for IF/ID
    // ------------------------------------------------------------------------
    fetch_fifo #(
        .DEPTH     (FETCH_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (w_fifo_push),
        .push_data (w_rsp_entry),
        .pop       (w_fifo_pop),
        .head      (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Delayed reset keeps requests off during the first cycle after reset release
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_q <= 1'b1;
        end else begin
            r_rst_q <= 1'b0;
        end
    end

    // Fetch PC: redirect target takes priority over sequential advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= word_align(redirect_pc);
        end else if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
        end
    end

    // Pending-PC storage: address of every accepted request, in issue order
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_pq[r_pq_wr] <= r_fetch_pc;
        end
    end

    // Pending-PC pointers; a redirect abandons everything in flight
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_pq_rd  <= '0;
            r_pq_wr  <= '0;
            r_pq_cnt <= '0;
        end else begin
            if (w_req_fire) begin
                r_pq_wr <= r_pq_wr + PTR_W'(1);
            end
            if (w_pq_pop) begin
                r_pq_rd <= r_pq_rd + PTR_W'(1);
            end
            r_pq_cnt <= r_pq_cnt + CNT_W'(w_req_fire) - CNT_W'(w_pq_pop);
        end
    end

    // Discard counter: number of stale responses still to be swallowed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_discard_cnt <= '0;
        end else if (redirect_valid) begin
            r_discard_cnt <= w_redirect_discard;
        end else if (imem_rsp_valid && w_discarding) begin
            r_discard_cnt <= r_discard_cnt - CNT_W'(1);
        end
    end

    // IF/ID register: FIFO head first, then bypassed response, else a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc4      <= '0;
            r_if_valid <= 1'b0;
        end else if (flush || redirect_valid) begin
            r_instr    <= NOP_INSTR;
            r_if_valid <= 1'b0;
        end else if (!stall) begin
            if (!w_fifo_empty) begin
                r_instr    <= w_fifo_head.instr;
                r_pc       <= w_fifo_head.pc;
                r_pc4      <= w_fifo_head.pc + ADDR_WIDTH'(4);
                r_if_valid <= 1'b1;
            end else if (w_bypass) begin
                r_instr    <= w_rsp_entry.instr;
                r_pc       <= w_rsp_entry.pc;
                r_pc4      <= w_rsp_entry.pc + ADDR_WIDTH'(4);
                r_if_valid <= 1'b1;
            end else begin
                r_instr    <= NOP_INSTR;
                r_if_valid <= 1'b0;
            end
        end
    end

    assign instruction = r_instr;
    assign PC          = r_pc;
    assign PC_plus_4   = r_pc4;
    assign if_valid    = r_if_valid;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage with an in-order
//            fixed-latency instruction memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instruction;
    logic [31:0] PC;
    logic [31:0] PC_plus_4;
    logic        if_valid;

    int checks   = 0;
    int failures = 0;

    if_stage #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .RESET_PC       (32'h0000_0000),
        .FETCH_DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction    (instruction),
        .PC             (PC),
        .PC_plus_4      (PC_plus_4),
        .if_valid       (if_valid)
    );

    always #5 clk = ~clk;

    // Instruction word stored at an address (distinct per address, never NOP)
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Memory model: fixed latency, in order, responses always accepted
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        int          rem;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] acc_log[$];
    int          lat     = 1;
    int          max_out = 0;

    initial begin
        logic        s_acc;
        logic [31:0] s_addr;
        logic        s_rst;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            s_acc  = imem_req_valid && imem_req_ready;
            s_addr = imem_req_addr;
            s_rst  = rst;
            if (s_acc && !s_rst) acc_log.push_back(s_addr);
            @(posedge clk);
            #1;
            if (s_rst) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (imem_rsp_valid) void'(mq.pop_front());
                foreach (mq[j]) if (mq[j].rem > 0) mq[j].rem--;
                if (s_acc) mq.push_back('{s_addr, lat - 1});
                if (mq.size() > max_out) max_out = mq.size();
                if (mq.size() > 0 && mq[0].rem == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = imem_word(mq[0].addr);
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // Returns at #1 after the edge on which rst was released (cycle C0)
    task automatic do_reset(input int latency);
        lat            = latency;
        rst            = 1'b1;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr",  imem_req_addr,       32'h0);
        chk("rst_instr",     instruction,         NOP);
        chk("rst_pc",        PC,                  32'h0);
        chk("rst_pc4",       PC_plus_4,           32'h0);
        chk("rst_if_valid",  32'(if_valid),       32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        acc_log.delete();
    endtask

    // Advance at least one cycle until IF/ID holds a real instruction
    task automatic next_valid(input string name);
        bit found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk({name, "_seen"}, 32'(found), 32'h1);
    endtask

    // ------------------------------------------------------------------------
    // Per-cycle vector table for the 1-cycle-memory stream
    // ------------------------------------------------------------------------
    typedef struct {
        logic        stall;
        logic        flush;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic f, input logic rv,
                                input logic [31:0] a, input logic iv,
                                input logic [31:0] pc, input logic [31:0] p4);
        vec_t v;
        v.stall = s;  v.flush = f;  v.exp_rv = rv; v.exp_addr = a;
        v.exp_iv = iv; v.exp_pc = pc; v.exp_pc4 = p4;
        return v;
    endfunction

    vec_t vt[16];

    initial begin
        logic [31:0] exp_instr;

        //          stall flush  rv    addr          iv    PC            PC+4
        vt[0]  = mk(1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00);
        vt[1]  = mk(1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00);
        vt[2]  = mk(1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 32'h00);
        vt[3]  = mk(1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 32'h04);
        vt[4]  = mk(1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h08);
        vt[5]  = mk(1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h04, 32'h08);
        vt[6]  = mk(1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h04, 32'h08);
        vt[7]  = mk(1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h04, 32'h08);
        vt[8]  = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08, 32'h0C);
        vt[9]  = mk(1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h10);
        vt[10] = mk(1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10, 32'h14);
        vt[11] = mk(1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14, 32'h18);
        vt[12] = mk(1'b0, 1'b0, 1'b0, 32'h20, 1'b0, 32'h14, 32'h18);
        vt[13] = mk(1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h18, 32'h1C);
        vt[14] = mk(1'b0, 1'b0, 1'b1, 32'h24, 1'b1, 32'h1C, 32'h20);
        vt[15] = mk(1'b0, 1'b0, 1'b1, 32'h28, 1'b1, 32'h20, 32'h24);

        // ---- streaming, 3-cycle stall, one flush ------------------------------
        do_reset(1);
        for (int i = 0; i < 16; i++) begin
            stall = vt[i].stall;
            flush = vt[i].flush;
            @(negedge clk);
            exp_instr = vt[i].exp_iv ? imem_word(vt[i].exp_pc) : NOP;
            chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].exp_rv));
            chk($sformatf("v%0d_req_addr", i),  imem_req_addr,       vt[i].exp_addr);
            chk($sformatf("v%0d_if_valid", i),  32'(if_valid),       32'(vt[i].exp_iv));
            chk($sformatf("v%0d_pc", i),        PC,                  vt[i].exp_pc);
            chk($sformatf("v%0d_pc4", i),       PC_plus_4,           vt[i].exp_pc4);
            chk($sformatf("v%0d_instr", i),     instruction,         exp_instr);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        flush = 1'b0;

        // ---- redirect with two fetches in flight, 3-cycle memory -------------
        do_reset(3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        chk("a_credit_full", 32'(imem_req_valid), 32'h0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("a_new_addr",      imem_req_addr,       32'h0000_0100);
        chk("a_discard_credit", 32'(imem_req_valid), 32'h0);
        chk("a_bubble",        32'(if_valid),       32'h0);
        next_valid("a_first");
        chk("a_pc",    PC,          32'h0000_0100);
        chk("a_pc4",   PC_plus_4,   32'h0000_0104);
        chk("a_instr", instruction, imem_word(32'h0000_0100));
        next_valid("a_second");
        chk("a_pc_next", PC, 32'h0000_0104);

        // ---- redirect and stall together ------------------------------------
        do_reset(1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        chk("b_pre_pc", PC, 32'h0000_0004);
        @(posedge clk);
        #1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("b_bubble_valid", 32'(if_valid), 32'h0);
        chk("b_bubble_instr", instruction,   NOP);
        next_valid("b_first");
        chk("b_pc",    PC,          32'h0000_0100);
        chk("b_instr", instruction, imem_word(32'h0000_0100));

        // ---- ready held low for four cycles ---------------------------------
        do_reset(1);
        imem_req_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("c_hold%0d_valid", c), 32'(imem_req_valid), 32'h1);
            chk($sformatf("c_hold%0d_addr", c),  imem_req_addr,       32'h0);
        end
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        next_valid("c_first");
        chk("c_pc0", PC, 32'h0);
        next_valid("c_second");
        chk("c_pc1", PC, 32'h4);
        chk("c_log_size", 32'(acc_log.size() >= 3), 32'h1);
        if (acc_log.size() >= 3) begin
            chk("c_acc0", acc_log[0], 32'h0);
            chk("c_acc1", acc_log[1], 32'h4);
            chk("c_acc2", acc_log[2], 32'h8);
        end

        // ---- unaligned redirect target and address wrap ----------------------
        do_reset(1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(posedge clk);
        #1;
        redirect_pc    = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("d_aligned_addr", imem_req_addr, 32'h0000_0100);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("d_top_addr",  imem_req_addr,       32'hFFFF_FFFC);
        chk("d_top_valid", 32'(imem_req_valid), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("d_wrap_addr", imem_req_addr, 32'h0000_0000);
        next_valid("d_first");
        chk("d_pc",  PC,        32'hFFFF_FFFC);
        chk("d_pc4", PC_plus_4, 32'h0000_0000);
        next_valid("d_second");
        chk("d_pc_wrap", PC, 32'h0000_0000);

        chk("max_outstanding", 32'(max_out <= 2), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule : tb_if_stage
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction Fetch stage of the RV32I 5-stage pipeline: owns the fetch PC, issues requests to a variable-latency instruction memory, and buffers in-order responses. It holds the IF/ID pipeline register that feeds the decode stage with instruction, PC and PC+4. It accepts branch/jump redirects from EX and stall/flush from the hazard unit, and discards stale in-flight fetches after a redirect.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, PC/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FETCH_DEPTH, 2, maximum in-flight plus buffered fetches (≥2, power of 2)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold the IF/ID register
- flush  in  1  invalidate the IF/ID register
- redirect_valid  in  1  taken branch/jump from EX
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored and forced to 0
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_WIDTH  fetch address
- imem_rsp_valid  in  1  response valid; in order; always accepted
- imem_rsp_data  in  DATA_WIDTH  fetched instruction
- instruction  out  DATA_WIDTH  IF/ID instruction
- PC  out  ADDR_WIDTH  IF/ID PC
- PC_plus_4  out  ADDR_WIDTH  IF/ID PC+4
- if_valid  out  1  IF/ID holds a real instruction

## Operation
- fetch_pc register. On request accept (valid&ready): fetch_pc += 4, with mod-2^ADDR_WIDTH wrap. On redirect_valid: fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}. Redirect wins over accept.
- Credit: occ = pending + fifo_count. imem_req_valid = !rst_q && (occ < FETCH_DEPTH). The signal is derived from registered state only, with no combinational path from redirect, stall or ready.
- Every accepted request pushes its address into a pending-PC queue. Each response pops the head and forms {pc, instr}.
- Response routing, when not discarding:
  - If the FIFO is empty and the IF/ID register can load, the pair is bypassed into IF/ID.
  - Otherwise the pair is pushed into the instruction FIFO.
  - occ ≤ FETCH_DEPTH guarantees the FIFO never overflows.
- IF/ID load: it loads when !stall. Source is the FIFO head if non-empty, else the bypassed response, else a bubble: instruction=NOP (32'h0000_0013), if_valid=0. PC/PC_plus_4 hold their previous value on a bubble.
- Flush (with or without redirect): IF/ID becomes a bubble. Flush overrides stall.
- Redirect, in the same cycle:
  - FIFO and pending-PC queue are cleared.
  - discard_cnt <= pending outstanding, counting the request accepted this cycle and excluding a response arriving this cycle (which is dropped).
  - IF/ID becomes a bubble.
- Discard mode: while discard_cnt>0, responses are dropped and discard_cnt decrements. New requests to the redirected PC may issue meanwhile, subject to occ, which counts discard-pending responses.
- A request that is valid but not ready is held stable (addr unchanged) unless a redirect occurs. After a redirect the next cycle presents the new address; the memory tolerates this retarget.

## Timing
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC
  - instruction=NOP, PC=0, PC_plus_4=0, if_valid=0
  - FIFO, queues and discard_cnt empty
- The first request is issued in the first cycle after rst deasserts, at RESET_PC.
- Latency: with a response in cycle N and no stall, IF/ID is updated at the end of cycle N via bypass; outputs are visible in N+1.
- Throughput: one instruction per cycle with 1-cycle memory and FETCH_DEPTH=2.
- Stall: outputs are held for all stall cycles. Responses fill the FIFO, and requests stop when occ=FETCH_DEPTH.
- rst asserted mid-operation returns all state to reset values at the next edge. Outstanding responses after reset are not tracked; the memory is reset together with the stage.

## Structure
- if_pkg: NOP_INSTR constant, default RESET_PC, fetch_entry_t struct {pc, instr}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, depth FETCH_DEPTH, with push/pop/clear and full/empty/count outputs.
- Top-level if_stage: fetch_pc, credit logic, pending-PC queue, discard counter, IF/ID register.

## Test plan
- Reset, then 1-cycle memory, no stalls -> requests at 0,4,8,…. if_valid rises 2 cycles after rst drops; PC advances by 4 every cycle with the matching instruction.
- Stall 3 cycles mid-stream -> outputs frozen; at most 2 outstanding requests/buffered entries; after release, instructions continue with no loss or duplication.
- Redirect to 0x100 with 2 fetches in flight (3-cycle memory) -> the 2 stale responses are dropped; the next valid IF/ID has PC=0x100, PC_plus_4=0x104.
- Redirect and stall in the same cycle -> IF/ID becomes NOP with if_valid=0; the next valid instruction is from 0x100.
- imem_req_ready low for 4 cycles -> addr held stable; no duplicate fetch after ready rises.
- redirect_pc=0x103 -> fetch issued at 0x100. fetch_pc at 0xFFFF_FFFC wraps to 0x0000_0000.
